fir_sample_fifo: RTL and testbench

- Input sample buffer for the FIR datapath. It sits directly upstream of control_fsm.
- Stores samples pushed by the external source via PushIn/DataIn.
- Presents the oldest sample first-word-fall-through (FWFT) to the multiplier input.
- Reports fifo_empty to the control FSM, and pops one entry per fifoPullOut pulse issued by that FSM.

---
 rtl/fir_sample_fifo.sv | 85 ++++++++
 tb/tb_fir_sample_fifo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fir_sample_fifo.sv
// FWFT input sample buffer feeding the FIR multiplier. Occupancy is held in an
// explicit counter, and every output (head data and flags) comes from a register.
module fir_sample_fifo #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PushIn,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              fifoPullOut,
  output logic [DATA_W-1:0] DataOut,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              push_acc;
  logic              pull_acc;
  logic [PTR_W-1:0]  wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] data_out_nxt;

  // Accept logic, pointer/count update and next head value.
  always_comb begin
    pull_acc     = fifoPullOut & ~fifo_empty;
    push_acc     = PushIn & (~fifo_full | pull_acc);
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = fifo_count;
    data_out_nxt = DataOut;

    if (push_acc) wr_ptr_nxt = wr_ptr + PTR_W'(1);
    if (pull_acc) rd_ptr_nxt = rd_ptr + PTR_W'(1);

    if (push_acc && !pull_acc)      count_nxt = fifo_count + CNT_W'(1);
    else if (!push_acc && pull_acc) count_nxt = fifo_count - CNT_W'(1);

    // The slot being written this edge becomes the head only when the FIFO
    // was empty, or held exactly one entry that is being pulled; bypass it.
    if (count_nxt != '0) begin
      if (push_acc && (rd_ptr_nxt == wr_ptr)) data_out_nxt = DataIn;
      else                                    data_out_nxt = mem[rd_ptr_nxt];
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= DataIn;
  end

  // Pointers, counter, registered flags and head data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      DataOut    <= '0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
      fifo_empty <= (count_nxt == '0);
      fifo_full  <= (count_nxt == CNT_W'(DEPTH));
      DataOut    <= data_out_nxt;
      if (PushIn && !push_acc)      overflow  <= 1'b1;
      if (fifoPullOut && !pull_acc) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sample_fifo.sv
// Directed bench for fir_sample_fifo: a queue scoreboard tracks expected
// contents and sticky flags; heads are compared when a pull is issued.
module tb_fir_sample_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              PushIn;
  logic [DATA_W-1:0] DataIn;
  logic              fifoPullOut;
  logic [DATA_W-1:0] DataOut;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic              underflow;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb [$];
  logic              m_over;
  logic              m_under;

  fir_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .PushIn     (PushIn),
    .DataIn     (DataIn),
    .fifoPullOut(fifoPullOut),
    .DataOut    (DataOut),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all status outputs, and the head when the model holds data.
  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 32'(fifo_count), 32'(sb.size()));
    chk({tag, ".empty"}, 32'(fifo_empty), 32'(sb.size() == 0));
    chk({tag, ".full"}, 32'(fifo_full), 32'(sb.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_over));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_under));
    if (sb.size() != 0) chk({tag, ".head"}, DataOut, sb[0]);
  endtask

  // One clock of stimulus; the scoreboard decides what the DUT must accept.
  task automatic step(input string tag, input logic p, input logic [31:0] d, input logic q);
    logic pull_ok;
    logic push_ok;
    logic [31:0] exp;
    PushIn      = p;
    DataIn      = d;
    fifoPullOut = q;
    pull_ok = q && (sb.size() != 0);
    push_ok = p && ((sb.size() != DEPTH) || pull_ok);
    if (pull_ok) begin
      exp = sb.pop_front();
      chk({tag, ".pull"}, DataOut, exp);
    end
    if (q && !pull_ok) m_under = 1'b1;
    if (p && !push_ok) m_over  = 1'b1;
    if (push_ok) sb.push_back(d);
    @(posedge clk);
    #1;
    PushIn      = 1'b0;
    fifoPullOut = 1'b0;
    chk_state(tag);
  endtask

  task automatic do_reset(input string tag, input int cycles, input logic p, input logic q);
    reset       = 1'b1;
    PushIn      = p;
    DataIn      = 32'hDEAD_BEEF;
    fifoPullOut = q;
    repeat (cycles) @(posedge clk);
    #1;
    reset       = 1'b0;
    PushIn      = 1'b0;
    fifoPullOut = 1'b0;
    sb.delete();
    m_over  = 1'b0;
    m_under = 1'b0;
    chk_state(tag);
    chk({tag, ".dataout"}, DataOut, 32'h0);
  endtask

  initial begin
    reset = 1'b1; PushIn = 1'b0; DataIn = '0; fifoPullOut = 1'b0;
    m_over = 1'b0; m_under = 1'b0;

    // Reset with both strobes high; nothing may be stored.
    do_reset("rst", 2, 1'b1, 1'b1);
    repeat (2) step("idle", 1'b0, 32'h0, 1'b0);

    // FWFT ordering.
    step("fwft_push", 1'b1, 32'h11, 1'b0);
    chk("fwft_first", DataOut, 32'h11);
    step("fwft_push", 1'b1, 32'h22, 1'b0);
    step("fwft_push", 1'b1, 32'h33, 1'b0);
    repeat (3) step("fwft_pull", 1'b0, 32'h0, 1'b1);
    chk("fwft_empty", 32'(fifo_empty), 32'h1);

    // Fill to full, then push and pull together at full.
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 32'(i), 1'b0);
    chk("full_flag", 32'(fifo_full), 32'h1);
    chk("full_count", 32'(fifo_count), 32'd16);
    step("full_pushpull", 1'b1, 32'hAA, 1'b1);
    chk("full_pp_over", 32'(overflow), 32'h0);
    for (int i = 0; i < 16; i++) step("drain_pp", 1'b0, 32'h0, 1'b1);
    chk("drain_pp_empty", 32'(fifo_empty), 32'h1);

    // Overfill: sample 16 is dropped.
    for (int i = 0; i < 17; i++) step("overfill", 1'b1, 32'(i), 1'b0);
    chk("overflow_set", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 32'h0, 1'b1);

    // Pull while empty, also with a push in the same cycle.
    step("empty_pull", 1'b0, 32'h0, 1'b1);
    chk("underflow_set", 32'(underflow), 32'h1);
    step("empty_pushpull", 1'b1, 32'h77, 1'b1);
    step("empty_pp_drain", 1'b0, 32'h0, 1'b1);

    // Push/pull pairs across pointer wrap, then overlapped push+pull at count 1.
    for (int i = 0; i < 40; i++) begin
      step("wrap_push", 1'b1, 32'(i), 1'b0);
      step("wrap_pull", 1'b0, 32'h0, 1'b1);
    end
    step("c1_push", 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 20; i++) step("c1_pushpull", 1'b1, 32'h200 + 32'(i), 1'b1);
    step("c1_drain", 1'b0, 32'h0, 1'b1);

    // Mid-operation reset at count 5.
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 32'h40 + 32'(i), 1'b0);
    step("pre_rst_uf", 1'b0, 32'h0, 1'b0);
    do_reset("mid_rst", 1, 1'b0, 1'b0);
    step("post_rst_push", 1'b1, 32'h5A, 1'b0);
    chk("post_rst_head", DataOut, 32'h5A);
    step("post_rst_pull", 1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
